spi_cmd_ram: RTL and testbench

//  Parametrised, command-decoded single-port RAM. Sits behind the SPI slave.
//  - Consumes {cmd[1:0], payload} frames from the SPI slave.
//  - Returns read words to the slave through a valid/ready handshake.
//  - Optional address auto-increment supports burst writes and reads.
//  - Back-pressures the slave while a read response is outstanding.

---
 rtl/spi_cmd_ram.sv | 134 +++++++++++++
 tb/tb_spi_cmd_ram.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ram.sv
// spi_cmd_ram: command-decoded single-port RAM that sits behind the SPI slave.
// Each frame is {cmd[1:0], payload[WORD_W-1:0]}:
//   00 WR_ADDR  load the write address
//   01 WR_DATA  write payload at wr_addr (post-increment when AUTO_INC)
//   10 RD_ADDR  load the read address
//   11 RD_DATA  fetch mem[rd_addr] and return it on the tx handshake
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   rx_data/valid/ready frame input from the SPI slave; rx_ready = idle
//   tx_data/valid/ready read word back to the SPI slave; held until tx_ready
//   addr_err            one-cycle pulse when an address payload >= MEM_DEPTH
// ADDR_W = $clog2(MEM_DEPTH) must not exceed WORD_W.
//
// state | meaning
// IDLE  | ready for a frame; commands decoded on acceptance
// FETCH | one cycle: load tx_data from mem[rd_addr], raise tx_valid
// HOLD  | tx_valid high and stable until the slave asserts tx_ready
module spi_cmd_ram #(
  parameter int WORD_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              addr_err
);

  localparam int              ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [WORD_W:0] DEPTH_EXT = (WORD_W + 1)'(MEM_DEPTH);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  logic [1:0]        cmd;
  logic [WORD_W-1:0] payload;
  logic              accept;
  logic              addr_bad;

  assign cmd      = rx_data[WORD_W+1:WORD_W];
  assign payload  = rx_data[WORD_W-1:0];
  assign rx_ready = (state_q == IDLE);
  assign accept   = rx_valid && rx_ready;
  // Full-width compare also rejects any payload bits set above ADDR_W-1.
  assign addr_bad = {1'b0, payload} >= DEPTH_EXT;

  // Wraps at MEM_DEPTH-1 rather than at 2**ADDR_W so non-power-of-two depths work.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && cmd == CMD_RD_DATA) state_d = FETCH;
      FETCH:   state_d = HOLD;
      HOLD:    if (tx_valid && tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accepts only happen in IDLE, so the command decode and the FETCH
  // rd_addr increment never compete for the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      if (accept) begin
        unique case (cmd)
          CMD_WR_ADDR: begin
            if (addr_bad) addr_err <= 1'b1;
            else          wr_addr  <= payload[ADDR_W-1:0];
          end
          CMD_WR_DATA: begin
            if (AUTO_INC) wr_addr <= next_addr(wr_addr);
          end
          CMD_RD_ADDR: begin
            if (addr_bad) addr_err <= 1'b1;
            else          rd_addr  <= payload[ADDR_W-1:0];
          end
          default: ;
        endcase
      end
      if (state_q == FETCH) begin
        tx_data  <= mem[rd_addr];
        tx_valid <= 1'b1;
        if (AUTO_INC) rd_addr <= next_addr(rd_addr);
      end
      if (state_q == HOLD && tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && cmd == CMD_WR_DATA) begin
      mem[wr_addr] <= payload;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ram.sv
// tb_spi_cmd_ram: self-checking bench for spi_cmd_ram.
// Three instances share clk/rst_n: inst0 default (256, auto-inc),
// inst1 MEM_DEPTH=200, inst2 AUTO_INC=0. A reference model tracks memory and
// address registers per instance; RD_DATA acceptance pushes the expected word
// to a scoreboard queue that is popped at the tx handshake.
module tb_spi_cmd_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data  [3];
  logic       rx_valid [3];
  logic       rx_ready [3];
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       addr_err [3];

  int         depth [3];
  bit         inc   [3];
  logic [7:0] mm    [3][256];
  int         mwr   [3];
  int         mrd   [3];
  logic [7:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_cmd_ram #(.WORD_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .addr_err(addr_err[0])
  );

  spi_cmd_ram #(.WORD_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .addr_err(addr_err[1])
  );

  spi_cmd_ram #(.WORD_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data[2]), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .addr_err(addr_err[2])
  );

  task automatic model_accept(input int sel, input logic [1:0] cmd,
                              input logic [7:0] pl, output logic err);
    err = 1'b0;
    case (cmd)
      2'b00: if (int'(pl) >= depth[sel]) err = 1'b1; else mwr[sel] = int'(pl);
      2'b01: begin
        mm[sel][mwr[sel]] = pl;
        if (inc[sel]) mwr[sel] = (mwr[sel] + 1) % depth[sel];
      end
      2'b10: if (int'(pl) >= depth[sel]) err = 1'b1; else mrd[sel] = int'(pl);
      default: begin
        exp_q.push_back(mm[sel][mrd[sel]]);
        if (inc[sel]) mrd[sel] = (mrd[sel] + 1) % depth[sel];
      end
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mwr[i] = 0;
      mrd[i] = 0;
    end
    exp_q.delete();
  endtask

  // Returns at the negedge after the accepting edge, with rx_valid dropped.
  task automatic send_frame(input int sel, input logic [1:0] cmd, input logic [7:0] pl);
    int   n;
    logic err;
    @(negedge clk);
    rx_data[sel]  = {cmd, pl};
    rx_valid[sel] = 1'b1;
    n = 0;
    while (rx_ready[sel] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rx_ready[sel] !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout inst%0d rx_ready=%b want 1", sel, rx_ready[sel]);
      rx_valid[sel] = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(sel, cmd, pl, err);
    @(negedge clk);
    rx_valid[sel] = 1'b0;
    total++;
    if (addr_err[sel] !== err) begin
      bad++;
      $display("FAIL addr_err inst%0d cmd=%b pl=%h got=%b want=%b", sel, cmd, pl, addr_err[sel], err);
    end
  endtask

  // RD_DATA with `stall` cycles of tx_ready=0 in HOLD; optionally presents
  // another frame during HOLD that must only be taken after the handshake.
  task automatic do_read(input int sel, input int stall, input bit hold_en,
                         input logic [1:0] hold_cmd, input logic [7:0] hold_pl);
    logic [7:0] held;
    logic [7:0] exp;
    logic       err;
    tx_ready[sel] = (stall == 0);
    send_frame(sel, 2'b11, 8'h00);
    total++;
    if (tx_valid[sel] !== 1'b0) begin
      bad++;
      $display("FAIL fetch_latency inst%0d tx_valid=%b want 0", sel, tx_valid[sel]);
    end
    @(negedge clk);
    total++;
    if (tx_valid[sel] !== 1'b1) begin
      bad++;
      $display("FAIL hold_valid inst%0d tx_valid=%b want 1", sel, tx_valid[sel]);
    end
    held = tx_data[sel];
    if (hold_en) begin
      rx_data[sel]  = {hold_cmd, hold_pl};
      rx_valid[sel] = 1'b1;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      total++;
      if (tx_valid[sel] !== 1'b1 || tx_data[sel] !== held || rx_ready[sel] !== 1'b0) begin
        bad++;
        $display("FAIL stall inst%0d cyc=%0d tx_valid=%b tx_data=%h rx_ready=%b want 1/%h/0",
                 sel, i, tx_valid[sel], tx_data[sel], rx_ready[sel], held);
      end
    end
    tx_ready[sel] = 1'b1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL rd_data inst%0d got=%h want=<no expectation queued>", sel, tx_data[sel]);
    end else begin
      exp = exp_q.pop_front();
      if (tx_data[sel] !== exp) begin
        bad++;
        $display("FAIL rd_data inst%0d got=%h want=%h", sel, tx_data[sel], exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    tx_ready[sel] = 1'b0;
    total++;
    if (tx_valid[sel] !== 1'b0 || rx_ready[sel] !== 1'b1) begin
      bad++;
      $display("FAIL release inst%0d tx_valid=%b rx_ready=%b want 0/1", sel, tx_valid[sel], rx_ready[sel]);
    end
    if (hold_en) begin
      @(posedge clk);
      model_accept(sel, hold_cmd, hold_pl, err);
      @(negedge clk);
      rx_valid[sel] = 1'b0;
      total++;
      if (addr_err[sel] !== err) begin
        bad++;
        $display("FAIL held_addr_err inst%0d got=%b want=%b", sel, addr_err[sel], err);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (tx_valid[i] !== 1'b0 || rx_ready[i] !== 1'b1 || addr_err[i] !== 1'b0 || tx_data[i] !== 8'h00) begin
        bad++;
        $display("FAIL reset_vals inst%0d tx_valid=%b rx_ready=%b addr_err=%b tx_data=%h want 0/1/0/00",
                 i, tx_valid[i], rx_ready[i], addr_err[i], tx_data[i]);
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_rw();
    send_frame(0, 2'b00, 8'h10);
    send_frame(0, 2'b01, 8'hA5);
    send_frame(0, 2'b10, 8'h10);
    do_read(0, 0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_burst_wrap();
    send_frame(0, 2'b00, 8'hFE);
    send_frame(0, 2'b01, 8'h01);
    send_frame(0, 2'b01, 8'h02);
    send_frame(0, 2'b01, 8'h03);
    send_frame(0, 2'b10, 8'hFE);
    do_read(0, 0, 1'b0, 2'b00, 8'h00);
    do_read(0, 1, 1'b0, 2'b00, 8'h00);
    do_read(0, 2, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_back_pressure();
    send_frame(0, 2'b00, 8'h40);
    send_frame(0, 2'b01, 8'h01);
    send_frame(0, 2'b01, 8'h02);
    send_frame(0, 2'b00, 8'h40);
    send_frame(0, 2'b10, 8'h40);
    do_read(0, 5, 1'b1, 2'b01, 8'h77);
    send_frame(0, 2'b10, 8'h40);
    do_read(0, 0, 1'b0, 2'b00, 8'h00);
    do_read(0, 0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_depth200();
    send_frame(1, 2'b00, 8'h00);
    send_frame(1, 2'b01, 8'h44);
    send_frame(1, 2'b00, 8'hC7);
    send_frame(1, 2'b00, 8'hD0);
    @(negedge clk);
    total++;
    if (addr_err[1] !== 1'b0) begin
      bad++;
      $display("FAIL addr_err_pulse inst1 got=%b want 0", addr_err[1]);
    end
    send_frame(1, 2'b01, 8'h33);
    send_frame(1, 2'b01, 8'h55);
    send_frame(1, 2'b10, 8'hC7);
    send_frame(1, 2'b10, 8'hC8);
    send_frame(1, 2'b00, 8'hFF);
    do_read(1, 0, 1'b0, 2'b00, 8'h00);
    do_read(1, 1, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_no_autoinc();
    send_frame(2, 2'b00, 8'h20);
    send_frame(2, 2'b01, 8'h99);
    send_frame(2, 2'b00, 8'h21);
    send_frame(2, 2'b01, 8'h88);
    send_frame(2, 2'b00, 8'h20);
    send_frame(2, 2'b01, 8'h11);
    send_frame(2, 2'b01, 8'h22);
    send_frame(2, 2'b10, 8'h20);
    do_read(2, 0, 1'b0, 2'b00, 8'h00);
    do_read(2, 0, 1'b0, 2'b00, 8'h00);
    send_frame(2, 2'b10, 8'h21);
    do_read(2, 0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic test_reset_mid_read();
    send_frame(0, 2'b00, 8'h30);
    send_frame(0, 2'b01, 8'hC3);
    send_frame(0, 2'b10, 8'h30);
    tx_ready[0] = 1'b0;
    send_frame(0, 2'b11, 8'h00);
    @(negedge clk);
    total++;
    if (tx_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_read_hold inst0 tx_valid=%b want 1", tx_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid[0] !== 1'b0 || rx_ready[0] !== 1'b1 || tx_data[0] !== 8'h00) begin
      bad++;
      $display("FAIL async_reset inst0 tx_valid=%b rx_ready=%b tx_data=%h want 0/1/00",
               tx_valid[0], rx_ready[0], tx_data[0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 2'b01, 8'h5A);
    do_read(0, 0, 1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    depth[0] = 256; depth[1] = 200; depth[2] = 256;
    inc[0]   = 1'b1; inc[1] = 1'b1; inc[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data[i]  = '0;
      rx_valid[i] = 1'b0;
      tx_ready[i] = 1'b0;
    end
    model_reset();
    test_reset();
    test_single_rw();
    test_burst_wrap();
    test_back_pressure();
    test_depth200();
    test_no_autoinc();
    test_reset_mid_read();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
